// File: rtl/bambu_slave_port_reader_pkg.sv
// Shared definitions for the slave-port read-back initiator: FSM states and the
// default slave-port geometry used by both the block and the simulation harness.
package bambu_slave_port_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int DEF_CHANNELS = 2;
  localparam int DEF_ADDR_W   = 9;
  localparam int DEF_DATA_W   = 64;
  localparam int DEF_SIZE_W   = 7;

  function automatic int size_bits(input int elem_bytes);
    return elem_bytes * 8;
  endfunction

endpackage

// File: rtl/bambu_slave_port_reader.sv
// Reads num_elems fixed-size elements from the accelerator's slave memory port
// (channel 0 only) and streams them out on a valid/ready port.
module bambu_slave_port_reader
  import bambu_slave_port_reader_pkg::*;
#(
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SIZE_W     = DEF_SIZE_W,
  parameter int ELEM_BYTES = 4,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [CNT_W-1:0]             num_elems,
  output logic                         busy,
  output logic                         done,
  output logic                         err_timeout,
  output logic [CHANNELS-1:0]          S_oe_ram,
  output logic [CHANNELS-1:0]          S_we_ram,
  output logic [CHANNELS*ADDR_W-1:0]   S_addr_ram,
  output logic [CHANNELS*DATA_W-1:0]   S_Wdata_ram,
  output logic [CHANNELS*SIZE_W-1:0]   S_data_ram_size,
  input  logic [CHANNELS*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [CHANNELS-1:0]          Sout_DataRdy,
  output logic                         m_valid,
  output logic [ELEM_BYTES*8-1:0]      m_data,
  output logic                         m_last,
  input  logic                         m_ready,
  output state_e                       dbg_state
);

  localparam int ELEM_W = ELEM_BYTES * 8;
  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [SIZE_W-1:0] ELEM_SIZE = SIZE_W'(size_bits(ELEM_BYTES));

  // Output handshake: an element transfers on any cycle where m_valid && m_ready;
  // m_data/m_last stay stable while m_valid is high and m_ready is low.

  state_e             state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [CNT_W-1:0]   rem_q;
  logic [WCNT_W-1:0]  wcnt_q;
  logic [ELEM_W-1:0]  data_q;
  logic               err_q;
  logic               is_req;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      wcnt_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q  <= base_addr;
            rem_q   <= num_elems;
            err_q   <= 1'b0;
            state_q <= (num_elems != '0) ? ST_REQ : ST_DONE;
          end
        end
        ST_REQ: begin
          // Counting down from TIMEOUT-1 gives exactly TIMEOUT cycles in WAIT.
          wcnt_q  <= WCNT_W'(TIMEOUT - 1);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (Sout_DataRdy[0]) begin
            data_q  <= Sout_Rdata_ram[ELEM_W-1:0];
            state_q <= ST_OUT;
          end else if (wcnt_q == '0) begin
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            wcnt_q <= wcnt_q - 1'b1;
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            addr_q  <= addr_q + ADDR_W'(ELEM_BYTES);
            rem_q   <= rem_q - 1'b1;
            state_q <= (rem_q != CNT_W'(1)) ? ST_REQ : ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign is_req      = (state_q == ST_REQ);
  assign busy        = (state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_OUT);
  assign done        = (state_q == ST_DONE);
  assign err_timeout = err_q;
  assign m_valid     = (state_q == ST_OUT);
  assign m_last      = (state_q == ST_OUT) && (rem_q == CNT_W'(1));
  assign m_data      = data_q;
  assign dbg_state   = state_q;

  // Only channel 0 is ever driven; upper channels fall out of the zero-extension.
  assign S_oe_ram        = CHANNELS'(is_req);
  assign S_we_ram        = '0;
  assign S_addr_ram      = (CHANNELS*ADDR_W)'({ADDR_W{is_req}} & addr_q);
  assign S_data_ram_size = (CHANNELS*SIZE_W)'({SIZE_W{is_req}} & ELEM_SIZE);
  assign S_Wdata_ram     = '0;

  logic unused_inputs;
  assign unused_inputs = ^{Sout_Rdata_ram[CHANNELS*DATA_W-1:ELEM_W], Sout_DataRdy[CHANNELS-1:1]};

endmodule

// File: tb/tb_bambu_slave_port_reader.sv
// Randomized scoreboard bench for bambu_slave_port_reader with a behavioural
// slave-memory responder and an element-level reference model.
module tb_bambu_slave_port_reader;
  import bambu_slave_port_reader_pkg::*;

  localparam int CH = 2, AW = 9, DW = 64, SW = 7, EB = 4, CW = 16, TO = 64;
  localparam int EW = EB * 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic              start = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [CW-1:0]     num_elems = '0;
  logic              busy, done, err_timeout;
  logic [CH-1:0]     S_oe_ram, S_we_ram;
  logic [CH*AW-1:0]  S_addr_ram;
  logic [CH*DW-1:0]  S_Wdata_ram;
  logic [CH*SW-1:0]  S_data_ram_size;
  logic [CH*DW-1:0]  Sout_Rdata_ram = '0;
  logic [CH-1:0]     Sout_DataRdy = '0;
  logic              m_valid, m_last;
  logic [EW-1:0]     m_data;
  logic              m_ready = 1'b0;
  state_e            dbg_state;

  bambu_slave_port_reader #(
    .CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW),
    .ELEM_BYTES(EB), .CNT_W(CW), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .num_elems(num_elems), .busy(busy), .done(done), .err_timeout(err_timeout),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_addr_q[$];
  logic [EW:0]   exp_q[$];          // {last, data}

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  // Memory contents seen through the slave port, as a function of byte address.
  function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] x;
    x = {23'd0, a};
    return {(x * 32'd2654435761) ^ 32'hDEAD_BEEF, (x * 32'd40503) ^ 32'h5A5A_1234 ^ (x << 20)};
  endfunction

  // ---------------- slave memory responder ----------------
  bit            pend = 0;
  bit            drop = 0;
  bit            noise_en = 1;
  int            cd = 0;
  int            lat_min = 1, lat_max = 1;
  logic [AW-1:0] pend_addr = '0;

  always @(negedge clock) begin
    if (reset && S_oe_ram[0]) begin
      pend      = 1;
      cd        = $urandom_range(lat_max, lat_min);
      pend_addr = S_addr_ram[AW-1:0];
    end
  end

  always @(posedge clock) begin
    #1;
    if (pend) begin
      cd--;
      Sout_DataRdy[1] = 1'($urandom_range(1, 0));
      if (cd == 0 && !drop) begin
        Sout_DataRdy[0] = 1'b1;
        Sout_Rdata_ram  = {$urandom, $urandom, mem_word(pend_addr)};
        pend = 0;
      end else begin
        Sout_DataRdy[0] = 1'b0;
      end
    end else begin
      // Stray pulses with garbage data while nothing is outstanding.
      Sout_DataRdy   = noise_en ? 2'($urandom_range(3, 0)) : 2'b00;
      Sout_Rdata_ram = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // ---------------- sink driver ----------------
  int ready_pct = 100;
  int stall_left = 0;
  int stalls_done = 0;

  always @(posedge clock) begin
    #1;
    if (stall_left > 0 && m_valid) begin
      m_ready = 1'b0;
      stall_left--;
      stalls_done++;
    end else begin
      m_ready = ($urandom_range(99, 0) < ready_pct);
    end
  end

  // ---------------- monitor ----------------
  int   cyc = 0;
  bit   done_armed = 0, done_seen = 0, exp_timeout = 0, in_op = 0;
  int   exp_n = 0, start_cyc = 0, last_beat_cyc = 0, last_oe_cyc = 0;
  logic prev_hold = 1'b0;
  logic [EW-1:0] prev_data = '0;
  logic [EW:0]   e;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (reset) begin
      check("static_zero", 64'({S_we_ram, S_oe_ram[1], S_Wdata_ram,
                                S_addr_ram[2*AW-1:AW], S_data_ram_size[2*SW-1:SW]} != '0), 64'd0);
      if (in_op && !done) check("busy", 64'(busy), 64'd1);
      if (S_oe_ram[0]) begin
        last_oe_cyc = cyc;
        check("oe_while_valid", 64'(m_valid), 64'd0);
        check("oe_size", 64'(S_data_ram_size[SW-1:0]), 64'd32);
        if (exp_addr_q.size() == 0) flag("unexpected_oe");
        else check("oe_addr", 64'(S_addr_ram[AW-1:0]), 64'(exp_addr_q.pop_front()));
      end
      if (prev_hold) begin
        check("m_valid_hold", 64'(m_valid), 64'd1);
        check("m_data_hold", 64'(m_data), 64'(prev_data));
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      if (m_valid && m_ready) begin
        last_beat_cyc = cyc;
        if (exp_q.size() == 0) flag("unexpected_beat");
        else begin
          e = exp_q.pop_front();
          check("beat", 64'({m_last, m_data}), 64'(e));
        end
      end
      if (done) begin
        check("done_busy", 64'(busy), 64'd0);
        if (!done_armed) flag("unexpected_done");
        else begin
          done_armed = 0;
          done_seen  = 1;
          in_op      = 0;
          check("err_timeout", 64'(err_timeout), 64'(exp_timeout));
          if (exp_timeout)     check("timeout_latency", 64'(cyc - last_oe_cyc), 64'(TO + 1));
          else if (exp_n == 0) check("empty_latency", 64'(cyc - start_cyc), 64'd1);
          else                 check("done_after_last", 64'(cyc - last_beat_cyc), 64'd1);
        end
      end
    end else begin
      prev_hold = 1'b0;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic arm(input int base, input int n, input bit drp);
    logic [AW-1:0] a;
    logic [63:0]   w;
    exp_n       = n;
    exp_timeout = drp && (n > 0);
    for (int i = 0; i < n; i++) begin
      a = AW'((base + EB * i) % (1 << AW));
      exp_addr_q.push_back(a);
      if (drp) break;
      w = mem_word(a);
      exp_q.push_back({(i == n - 1), w[EW-1:0]});
    end
    done_armed = 1;
    done_seen  = 0;
  endtask

  task automatic pulse_start(input int base, input int n);
    @(posedge clock); #1;
    start = 1'b1; base_addr = AW'(base); num_elems = CW'(n);
    start_cyc = cyc;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic do_read(input int base, input int n, input int llo, input int lhi,
                         input bit drp, input int pct);
    int bound;
    pend = 0; drop = drp; lat_min = llo; lat_max = lhi; ready_pct = pct;
    arm(base, n, drp);
    pulse_start(base, n);
    in_op = (n > 0);
    check("err_clear", 64'(err_timeout), 64'd0);
    bound = 200 + n * 200;
    for (int k = 0; k < bound && !done_seen; k++) @(negedge clock);
    @(negedge clock);
    check("done_seen", 64'(done_seen), 64'd1);
    check("beats_left", 64'(exp_q.size()), 64'd0);
    check("oe_left", 64'(exp_addr_q.size()), 64'd0);
    exp_q.delete(); exp_addr_q.delete();
    done_armed = 0; in_op = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_outputs", 64'({busy, done, err_timeout, S_oe_ram, S_we_ram, S_addr_ram,
                                S_data_ram_size, m_valid, m_last, m_data} != '0), 64'd0);
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    @(posedge clock); #1 reset = 1'b1;

    do_read(0, 3, 2, 2, 0, 100);                 // basic three-element read
    do_read(32'h20, 0, 1, 1, 0, 100);            // empty read
    stall_left = 5; stalls_done = 0;
    do_read(32'h10, 3, 1, 1, 0, 100);            // sink back-pressure
    check("stall_applied", 64'(stalls_done), 64'd5);
    do_read(32'h80, 2, 1, 1, 1, 100);            // responder never answers
    do_read(32'h84, 1, 1, 3, 0, 100);            // next start clears err_timeout
    do_read(32'h1FC, 2, 1, 3, 0, 100);           // address wrap

    // Abort mid-read with a stray start in between.
    pend = 0; drop = 0; lat_min = 4; lat_max = 4; ready_pct = 100;
    arm(32'h40, 4, 0);
    pulse_start(32'h40, 4);
    in_op = 1;
    pulse_start(32'h100, 5);
    begin
      bit found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
        @(negedge clock);
        if (dbg_state == ST_WAIT) found = 1;
      end
      check("reached_wait", 64'(found), 64'd1);
    end
    reset = 1'b0; done_armed = 0; in_op = 0;
    @(negedge clock);
    check("abort_outputs", 64'({busy, done, err_timeout, S_oe_ram, S_we_ram, S_addr_ram,
                                S_data_ram_size, m_valid, m_last, m_data} != '0), 64'd0);
    check("abort_state", 64'(dbg_state), 64'(ST_IDLE));
    exp_q.delete(); exp_addr_q.delete(); pend = 0;
    @(posedge clock); #1 reset = 1'b1;
    repeat (10) @(negedge clock);
    check("idle_after_abort", 64'(busy), 64'd0);

    // Randomized reads.
    for (int t = 0; t < 12; t++) begin
      do_read($urandom_range((1 << AW) - 1, 0), $urandom_range(6, 1),
              1, $urandom_range(4, 1), 0, $urandom_range(100, 60));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
